mode_counter: RTL

- Parametrised successor to the team's fixed-range saturating counter.
- Generalises width and range, with a runtime limit instead of an elaboration-time terminal value.
- Adds count direction, synchronous clear and load, and three modes: saturate, wrap, and one-shot (a small FSM).
- Used by control paths for timeouts, beat counting and delay generation.

---
 rtl/counter_pkg.sv | 13 +
 rtl/mode_counter_if.sv | 28 ++
 rtl/mode_counter.sv | 106 ++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode and FSM state definitions for mode_counter
package counter_pkg;

    localparam logic [1:0] MODE_SAT     = 2'd0;
    localparam logic [1:0] MODE_WRAP    = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mode_counter_if.sv
// rtl/mode_counter_if.sv - control and status bundle for mode_counter
interface mode_counter_if #(
    parameter int W = 3
);
    logic         en;
    logic         clr;
    logic         load;
    logic [W-1:0] load_val;
    logic         up;
    logic [W-1:0] limit;
    logic [1:0]   mode;
    logic         start;
    logic [W-1:0] count;
    logic         done;
    logic         wrap;
    logic         busy;
    logic         finish;

    modport master (
        output en, clr, load, load_val, up, limit, mode, start,
        input  count, done, wrap, busy, finish
    );

    modport slave (
        input  en, clr, load, load_val, up, limit, mode, start,
        output count, done, wrap, busy, finish
    );
endinterface

// File: rtl/mode_counter.sv
// rtl/mode_counter.sv - W-bit up/down counter with saturate, wrap and one-shot modes
module mode_counter
    import counter_pkg::*;
#(
    parameter int W          = 3,
    parameter int CLAMP_LOAD = 1
) (
    input  logic           clk,
    input  logic           rst,
    mode_counter_if.slave  bus
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_count;
    state_t       r_state;
    logic         r_wrap;
    logic         r_finish;

    logic [W-1:0] w_count_nxt;
    state_t       w_state_nxt;
    logic         w_wrap_nxt;
    logic         w_finish_nxt;
    logic [W-1:0] w_term;
    logic         w_oneshot;

    assign w_term    = bus.up ? bus.limit : '0;
    assign w_oneshot = (bus.mode == MODE_ONESHOT);

    // Next count, next FSM state and pulse flags; priority clr > load > start > step.
    // The increment is only taken while count < limit, so it can never overflow W bits.
    always_comb begin
        w_count_nxt  = r_count;
        w_state_nxt  = r_state;
        w_wrap_nxt   = 1'b0;
        w_finish_nxt = 1'b0;
        if (!w_oneshot) begin
            w_state_nxt = ST_IDLE;
        end
        if (bus.clr) begin
            w_count_nxt = '0;
            w_state_nxt = ST_IDLE;
        end else if (bus.load) begin
            if ((CLAMP_LOAD != 0) && (bus.load_val > bus.limit)) begin
                w_count_nxt = bus.limit;
            end else begin
                w_count_nxt = bus.load_val;
            end
        end else if (w_oneshot && (r_state == ST_IDLE)) begin
            if (bus.start) begin
                w_state_nxt = ST_RUN;
                w_count_nxt = bus.up ? '0 : bus.limit;
            end
        end else if (bus.en) begin
            if (w_oneshot && (r_count == w_term)) begin
                w_state_nxt  = ST_IDLE;
                w_finish_nxt = 1'b1;
            end else if (bus.up) begin
                if (r_count < bus.limit) begin
                    w_count_nxt = r_count + ONE;
                end else if (bus.mode == MODE_WRAP) begin
                    w_count_nxt = '0;
                    w_wrap_nxt  = 1'b1;
                end else begin
                    w_count_nxt = bus.limit;
                end
            end else begin
                if (r_count != '0) begin
                    w_count_nxt = r_count - ONE;
                end else if (bus.mode == MODE_WRAP) begin
                    w_count_nxt = bus.limit;
                    w_wrap_nxt  = 1'b1;
                end
            end
        end
    end

    // Count and single-cycle pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count  <= '0;
            r_wrap   <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_wrap   <= w_wrap_nxt;
            r_finish <= w_finish_nxt;
        end
    end

    // One-shot FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign bus.count  = r_count;
    assign bus.done   = (r_count == w_term);
    assign bus.wrap   = r_wrap;
    assign bus.busy   = (r_state == ST_RUN);
    assign bus.finish = r_finish;

endmodule
